// File: rtl/reg_bank_wb.sv
// Register bank for the multicycle MIPS datapath: 32 x DATA_W, $zero hardwired, $sp resets to SP_RESET.
// Optional write-through bypass on both read ports when REG_BANK_BYPASS_EN is defined.
module reg_bank_wb #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam logic [4:0] SP_ADDR = 5'd29;

    logic [DATA_W-1:0] regs [0:31];
    logic              wr_en;

    assign wr_en = RegWrite && (WriteReg != 5'd0);

    // NOTE: this array is reset like ordinary flops (the $sp value must exist
    // before the first write), so it cannot map onto a RAM macro; the
    // non-blocking updates keep the reads in the same cycle seeing old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (5'(i) == SP_ADDR) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic byp1;
    logic byp2;

    // Bypass only when a write would really be committed at the next edge.
    assign byp1 = !reset && wr_en && (WriteReg == ReadReg1);
    assign byp2 = !reset && wr_en && (WriteReg == ReadReg2);

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != 5'd0) ReadData1 = byp1 ? WriteData : regs[ReadReg1];
        if (ReadReg2 != 5'd0) ReadData2 = byp2 ? WriteData : regs[ReadReg2];
    end
`else
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ReadReg1 != 5'd0) ReadData1 = regs[ReadReg1];
        if (ReadReg2 != 5'd0) ReadData2 = regs[ReadReg2];
    end
`endif

endmodule

// File: doc/reg_bank_wb.md
# reg_bank_wb

Register bank of the multicycle MIPS datapath, directly downstream of the write-register selector mux. It consumes the 5-bit destination address chosen by that mux (rd, rt or $ra) plus the write-back data, and holds the 32 architectural registers read by the decode stage into the A/B operand registers. $zero is hardwired to 0. $sp ($29) resets to the top-of-stack value.

## Interface
- DATA_W, 32: register width in bits
- SP_RESET, 227: reset value of register 29 ($sp)
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- RegWrite  input  1  write enable for the current cycle
- ReadReg1  input  5  read address, port 1 (rs)
- ReadReg2  input  5  read address, port 2 (rt)
- WriteReg  input  5  write address, driven by the write-register selector mux
- WriteData  input  DATA_W  write-back data
- ReadData1  output  DATA_W  contents of ReadReg1
- ReadData2  output  DATA_W  contents of ReadReg2

## Operation
- Storage: 32 entries × DATA_W.
- Reset (reset=1, asynchronous, no clock needed): every entry cleared to 0 except entry 29 = SP_RESET. While reset is high, writes are ignored. Outputs follow the reset contents combinationally: address 29 reads SP_RESET, all others read 0.
- Write: on rising clk with reset=0, RegWrite=1 and WriteReg≠0, entry[WriteReg] ← WriteData.
- WriteReg=0 with RegWrite=1 is a silent no-op. Entry 0 is never written and always reads 0.
- RegWrite=0: no entry changes, whatever WriteReg/WriteData hold.
- Read: ReadDataN = entry[ReadRegN], purely combinational from the array.
  - Address 0 always reads 0.
  - Both ports may address the same entry; both return the same value.
- No internal FSM. State is the array only. A write to entry 29 overwrites SP_RESET normally.
- Reset deasserted mid-cycle: the first write is taken on the first rising edge where reset is already low.

## Timing
- Write latency: 1 edge. Data written at edge N is visible on ReadData from just after edge N.
- Read latency: 0 cycles, combinational from address and stored contents.
- Same-cycle read of the address being written (without the configured bypass): ReadData shows the old value until the edge, then the new value.
- reset asserted at any time clears the array immediately; an edge coinciding with reset writes nothing.
- No handshake. The controller guarantees WriteReg/WriteData are stable across the RegWrite edge.

## Configuration
- REG_BANK_BYPASS_EN defined: write-through bypass.
  - For each read port: if reset=0, RegWrite=1, WriteReg≠0 and WriteReg==ReadRegN, ReadDataN = WriteData combinationally in the same cycle, before the edge.
  - Address 0 is still forced to 0.
  - Array update is unchanged.
- REG_BANK_BYPASS_EN undefined: no bypass. Reads always reflect stored contents, as described in Timing.

## Test plan
- Reset: assert reset asynchronously mid-cycle, no clock edge -> ReadReg1=29 gives 227, ReadReg2=5 gives 0; after writes, assert reset -> all entries read 0, entry 29 reads 227.
- Basic write/read: RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, one edge -> ReadReg1=8 and ReadReg2=8 both give 0xDEADBEEF; then RegWrite=0, WriteData=0x1 for 3 edges -> still 0xDEADBEEF.
- $zero protection: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, edge -> ReadReg1=0 gives 0, and no other entry changes.
- $ra path: WriteReg=31, WriteData=0x00000040, edge -> ReadReg2=31 gives 0x40; entry 29 rewritten with 0x100 -> reads 0x100.
- Read-during-write: entry 10 = 0x5, then RegWrite=1, WriteReg=10, WriteData=0x7, ReadReg1=10 before the edge:
  - without REG_BANK_BYPASS_EN -> 0x5 before the edge, 0x7 after;
  - with REG_BANK_BYPASS_EN -> 0x7 before the edge.
- Reset coinciding with a write edge: reset=1, RegWrite=1, WriteReg=12, WriteData=0xAA -> entry 12 reads 0 after reset is released.
